simon_dice: RTL and testbench
=============================

SIMON_DICE -- requirements
Module: simon_dice

Interface
REQ-001 Parameter SEQ_MAX, 16: maximum sequence length; reaching it wins the game.
REQ-002 Parameter ON_CYCLES, 8: clock cycles each sequence LED is lit during playback.
REQ-003 Parameter OFF_CYCLES, 4: dark clock cycles after each playback LED.
REQ-004 Parameter BLINK_CYCLES, 8: half-period of the lose/win blink, in clock cycles.
REQ-005 clk  input  1  system clock; all state changes on the rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-low.
REQ-007 button  input  4  player buttons, active-high, asynchronous to clk; bit i selects color i.
REQ-008 led  output  4  color lamps, active-high, registered.

Function
REQ-009 button SHALL pass through a 2-flop synchronizer; a press is the rising edge of "any bit set" on the synchronized value; a press SHALL be held at least 1 full clock to be seen.
REQ-010 The pressed code SHALL be the synchronized value at the press edge; any value that is not one-hot SHALL count as a wrong entry.
REQ-011 A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) SHALL advance every clock from reset release; color = lfsr[1:0].
REQ-012 Sequence storage: SEQ_MAX x 2-bit entries; len counter 0..SEQ_MAX; idx counter for playback and input.
REQ-013 State IDLE: led=0000; a press -> ADD with len=0.
REQ-014 ADD: store color at entry[len], len++, idx=0 -> SHOW_ON (1 cycle).
REQ-015 SHOW_ON: led=one-hot(entry[idx]) for ON_CYCLES -> SHOW_OFF.
REQ-016 SHOW_OFF: led=0000 for OFF_CYCLES; then idx++ and -> SHOW_ON if idx<len, else idx=0 -> WAIT_IN.
REQ-017 WAIT_IN: led mirrors the synchronized button value while any button is held; at a press, compare against one-hot(entry[idx]).
REQ-018 A match with idx<len-1: idx++ and stay in WAIT_IN.
REQ-019 A match with idx=len-1: -> WIN if len=SEQ_MAX, else wait for all buttons to be released, then -> ADD.
REQ-020 Mismatch -> LOSE.
REQ-021 LOSE: led toggles between 1111 and 0000 every BLINK_CYCLES, starting at 1111; a press -> IDLE (len cleared).
REQ-022 WIN: led toggles between 1010 and 0101 every BLINK_CYCLES; a press -> IDLE.
REQ-023 Presses during ADD/SHOW_ON/SHOW_OFF SHALL be ignored; no press queueing.
REQ-024 Press detection on exit from LOSE/WIN SHALL use the same edge rule, so a button held across the transition is not a new press.
REQ-025 Timers count from 0 and reload on every state entry; there is no input timeout.

Reset
REQ-026 With rst=0: state=IDLE; led=0000; len=idx=0; timers=0; LFSR=16'hACE1; synchronizer flops=0; stored entries need not be cleared.
REQ-027 Reset asserted mid-game SHALL abort immediately, without waiting for a clock edge; after release the next game starts from len=0.

Verification
REQ-028 Assert rst=0 for 3 cycles with button=4'b0100 -> led=0000 throughout; state IDLE after release.
REQ-029 Release rst, then press button=4'b0100 for 2 cycles -> after synchronizer latency, led=one-hot(model LFSR[1:0] at ADD) for exactly 8 cycles, then 0000 for 4 cycles, then WAIT_IN.
REQ-030 In WAIT_IN, press the correct one-hot code -> led echoes the press; after release, round 2 plays 2 colors (8 on / 4 off each), entry 0 unchanged.
REQ-031 In WAIT_IN, press a wrong code, and separately 4'b0011 -> LOSE; led=1111 for 8 cycles, 0000 for 8, repeating; a press returns to IDLE with led=0000.
REQ-032 With SEQ_MAX=2, enter two correct rounds -> WIN; led alternates 1010/0101 every 8 cycles.
REQ-033 Drive rst=0 during SHOW_ON -> led=0000 in the same cycle without a clock edge; a new game restarts with len=1.

Source files
------------

// File: rtl/simon_dice.sv
// Simon-says memory game: plays a growing random color sequence on four lamps,
// then checks the player's button entries against it.
module simon_dice #(
    parameter int SEQ_MAX      = 16,
    parameter int ON_CYCLES    = 8,
    parameter int OFF_CYCLES   = 4,
    parameter int BLINK_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] button,
    output logic [3:0] led
);

    localparam int LW   = $clog2(SEQ_MAX + 1);
    localparam int IW   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;
    localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ?
                          ((ON_CYCLES > BLINK_CYCLES) ? ON_CYCLES : BLINK_CYCLES) :
                          ((OFF_CYCLES > BLINK_CYCLES) ? OFF_CYCLES : BLINK_CYCLES);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADD      = 3'd1;
    localparam logic [2:0] S_SHOW_ON  = 3'd2;
    localparam logic [2:0] S_SHOW_OFF = 3'd3;
    localparam logic [2:0] S_WAIT_IN  = 3'd4;
    localparam logic [2:0] S_WAIT_REL = 3'd5;
    localparam logic [2:0] S_LOSE     = 3'd6;
    localparam logic [2:0] S_WIN      = 3'd7;

    logic [3:0]    r_sync1, r_sync2;
    logic          r_any_d;
    logic [15:0]   r_lfsr;
    logic [2:0]    r_state;
    logic [LW-1:0] r_len, r_idx;
    logic [TW-1:0] r_timer;
    logic          r_blink;
    logic [3:0]    r_led;
    logic [1:0]    r_entry [0:(1<<IW)-1];

    logic       w_any, w_press, w_fb;
    logic [1:0] w_cur;
    logic [3:0] w_cur_oh;
    logic       w_last, w_full, w_on_done, w_off_done, w_blink_done;

    assign w_any        = |r_sync2;
    assign w_press      = w_any & ~r_any_d;
    assign w_fb         = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_cur        = r_entry[r_idx[IW-1:0]];
    assign w_cur_oh     = 4'b0001 << w_cur;
    assign w_last       = (r_idx + LW'(1)) == r_len;
    assign w_full       = r_len == LW'(SEQ_MAX);
    assign w_on_done    = r_timer == TW'(ON_CYCLES - 1);
    assign w_off_done   = r_timer == TW'(OFF_CYCLES - 1);
    assign w_blink_done = r_timer == TW'(BLINK_CYCLES - 1);
    assign led          = r_led;

    // Edge tracking runs in every state, so a button held across a state
    // change never registers as a fresh press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_any_d <= 1'b0;
            r_lfsr  <= 16'hACE1;
        end else begin
            r_sync1 <= button;
            r_sync2 <= r_sync1;
            r_any_d <= w_any;
            r_lfsr  <= {w_fb, r_lfsr[15:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_ADD)
            r_entry[r_len[IW-1:0]] <= r_lfsr[1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_idx   <= '0;
            r_timer <= '0;
            r_blink <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_press) begin
                        r_len   <= '0;
                        r_idx   <= '0;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_len   <= r_len + LW'(1);
                    r_idx   <= '0;
                    r_timer <= '0;
                    r_state <= S_SHOW_ON;
                end
                S_SHOW_ON: begin
                    if (w_on_done) begin
                        r_timer <= '0;
                        r_state <= S_SHOW_OFF;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_SHOW_OFF: begin
                    if (w_off_done) begin
                        r_timer <= '0;
                        if (w_last) begin
                            r_idx   <= '0;
                            r_state <= S_WAIT_IN;
                        end else begin
                            r_idx   <= r_idx + LW'(1);
                            r_state <= S_SHOW_ON;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_WAIT_IN: begin
                    // Blink phase is primed here since LOSE/WIN are only entered from this state
                    r_timer <= '0;
                    r_blink <= 1'b0;
                    if (w_press) begin
                        if (r_sync2 == w_cur_oh) begin
                            if (w_last)
                                r_state <= w_full ? S_WIN : S_WAIT_REL;
                            else
                                r_idx <= r_idx + LW'(1);
                        end else begin
                            r_state <= S_LOSE;
                        end
                    end
                end
                S_WAIT_REL: begin
                    if (!w_any)
                        r_state <= S_ADD;
                end
                S_LOSE, S_WIN: begin
                    if (w_press) begin
                        r_len   <= '0;
                        r_idx   <= '0;
                        r_timer <= '0;
                        r_state <= S_IDLE;
                    end else if (w_blink_done) begin
                        r_timer <= '0;
                        r_blink <= ~r_blink;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led <= '0;
        end else begin
            case (r_state)
                S_SHOW_ON:              r_led <= w_cur_oh;
                S_WAIT_IN, S_WAIT_REL:  r_led <= r_sync2;
                S_LOSE:                 r_led <= r_blink ? 4'b0000 : 4'b1111;
                S_WIN:                  r_led <= r_blink ? 4'b0101 : 4'b1010;
                default:                r_led <= 4'b0000;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_dice.sv
// Directed bench for simon_dice: a default-size game and a SEQ_MAX=2 game
// share stimulus; lamp outputs are checked every cycle on the falling edge.
module tb_simon_dice;

    logic       clk;
    logic       rst;
    logic [3:0] button;
    logic [3:0] led_a, led_b;
    logic [15:0] m_lfsr;
    logic [1:0]  col [0:3];
    int n_pass = 0;
    int n_tot  = 0;

    typedef struct {
        bit         rst;
        logic [3:0] btn;
        logic [3:0] exp;
        bit         use_col;
        bit         cap;
        string      nm;
    } vec_t;
    vec_t tbl[$];

    simon_dice dut_a (.clk(clk), .rst(rst), .button(button), .led(led_a));
    simon_dice #(.SEQ_MAX(2)) dut_b (.clk(clk), .rst(rst), .button(button), .led(led_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: taps 16,14,13,11, seed ACE1, free-running out of reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 16'hACE1;
        else      m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    function automatic logic [3:0] oh(logic [1:0] c);
        oh = 4'b0001 << c;
    endfunction

    task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: led=%b expected %b at %0t", nm, act, exp, $time);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic addv(bit r, logic [3:0] b, logic [3:0] e, bit uc, bit cp, string nm);
        vec_t v;
        v.rst = r; v.btn = b; v.exp = e; v.use_col = uc; v.cap = cp; v.nm = nm;
        tbl.push_back(v);
    endtask

    // Press edge is seen two clocks after the button changes; ADD is the third.
    task automatic new_game(int k);
        button = 4'b0100;
        step(); chk("ng_idle0", led_a, 4'b0000);
        step(); chk("ng_idle1", led_a, 4'b0000);
        button = 4'b0000;
        step(); chk("ng_idle2", led_a, 4'b0000);
        col[k] = m_lfsr[1:0];
    endtask

    task automatic wait_add(int k);
        step(); step(); step();
        col[k] = m_lfsr[1:0];
    endtask

    task automatic show(int n, string nm);
        step(); chk({nm, "_add"}, led_a, 4'b0000);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 8; i++) begin step(); chk({nm, "_on"}, led_a, oh(col[k])); end
            for (int i = 0; i < 4; i++) begin step(); chk({nm, "_off"}, led_a, 4'b0000); end
        end
        step(); chk({nm, "_waitin"}, led_a, 4'b0000);
    endtask

    task automatic enter(logic [3:0] code, string nm);
        button = code;
        step(); step(); step();
        chk({nm, "_echo"}, led_a, code);
        button = 4'b0000;
    endtask

    task automatic gap();
        step(); step(); step();
    endtask

    task automatic blink(bit use_b, logic [3:0] a, logic [3:0] b, int nph, string nm);
        for (int p = 0; p < nph; p++)
            for (int i = 0; i < 8; i++) begin
                step();
                chk(nm, use_b ? led_b : led_a, (p % 2 == 1) ? b : a);
            end
    endtask

    task automatic exit_press(bit use_b, string nm);
        button = 4'b0001;
        step(); step();
        button = 4'b0000;
        step();
        step(); chk(nm, use_b ? led_b : led_a, 4'b0000);
        step(); chk(nm, use_b ? led_b : led_a, 4'b0000);
    endtask

    initial begin
        rst    = 1'b0;
        button = 4'b0100;
        #1 chk("rst_async", led_a, 4'b0000);

        for (int i = 0; i < 3; i++) addv(0, 4'b0100, 4'b0000, 0, 0, "rst_hold");
        addv(1, 4'b0000, 4'b0000, 0, 0, "idle");
        addv(1, 4'b0000, 4'b0000, 0, 0, "idle");
        addv(1, 4'b0100, 4'b0000, 0, 0, "sync0");
        addv(1, 4'b0100, 4'b0000, 0, 0, "sync1");
        addv(1, 4'b0000, 4'b0000, 0, 1, "sync2");
        addv(1, 4'b0000, 4'b0000, 0, 0, "add");
        for (int i = 0; i < 8; i++) addv(1, 4'b0000, 4'b0000, 1, 0, "r1_on");
        for (int i = 0; i < 4; i++) addv(1, 4'b0000, 4'b0000, 0, 0, "r1_off");
        addv(1, 4'b0000, 4'b0000, 0, 0, "r1_waitin");

        for (int i = 0; i < tbl.size(); i++) begin
            rst    = tbl[i].rst;
            button = tbl[i].btn;
            step();
            if (tbl[i].cap) col[0] = m_lfsr[1:0];
            chk(tbl[i].nm, led_a, tbl[i].use_col ? oh(col[0]) : tbl[i].exp);
        end

        // round 2 replays entry 0 then a new color
        enter(oh(col[0]), "r1_in");
        wait_add(1);
        show(2, "r2");

        // correct first entry, wrong second -> LOSE
        enter(oh(col[0]), "r2_in0");
        gap();
        enter(oh(col[1] + 2'd1), "r2_wrong");
        blink(0, 4'b1111, 4'b0000, 3, "lose_blink");
        exit_press(0, "lose_exit");

        // non-one-hot entry is always wrong
        new_game(0);
        show(1, "g2");
        enter(4'b0011, "multi");
        blink(0, 4'b1111, 4'b0000, 2, "lose2_blink");
        exit_press(0, "lose2_exit");

        // asynchronous reset in the middle of playback
        new_game(0);
        step(); chk("g3_add", led_a, 4'b0000);
        for (int i = 0; i < 3; i++) begin step(); chk("g3_on", led_a, oh(col[0])); end
        #1 rst = 1'b0;
        #1 chk("mid_rst_async", led_a, 4'b0000);
        step(); chk("mid_rst_hold", led_a, 4'b0000);
        step(); chk("mid_rst_hold", led_a, 4'b0000);
        rst = 1'b1;
        step(); chk("mid_rst_idle", led_a, 4'b0000);
        new_game(0);
        show(1, "restart");
        step(); chk("restart_len1", led_a, 4'b0000);
        step(); chk("restart_len1", led_a, 4'b0000);

        // two correct rounds: SEQ_MAX=2 instance wins
        enter(oh(col[0]), "w1_in");
        wait_add(1);
        show(2, "w2");
        enter(oh(col[0]), "w2_in0");
        gap();
        enter(oh(col[1]), "w2_in1");
        blink(1, 4'b1010, 4'b0101, 3, "win_blink");
        exit_press(1, "win_exit");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
